// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types and constants for the master/slave pair
package spi_pkg;

  localparam int SPI_WORD_W     = 12;
  localparam int SPI_LEAD_EDGES = 1;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    DONE
  } rx_state_t;

endpackage

// File: rtl/spi_slave_rx_if.sv
// rtl/spi_slave_rx_if.sv - serial pins and parallel word port of the SPI receiver
interface spi_slave_rx_if #(
  parameter int WIDTH = spi_pkg::SPI_WORD_W
);

  logic             sclk;
  logic             cs;
  logic             mosi;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;

  // driver side: SPI master pins plus the word consumer
  modport master (
    output sclk, cs, mosi, dout_ready,
    input  dout, dout_valid, busy, frame_err, overrun
  );

  // receiver side
  modport slave (
    input  sclk, cs, mosi, dout_ready,
    output dout, dout_valid, busy, frame_err, overrun
  );

endinterface

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - N-flop synchronizer with configurable reset value
module spi_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  generate
    if (N == 1) begin : g_single
      // single-stage capture
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= RST_VAL;
        else     ff <= d;
      end
    end else begin : g_chain
      // shift the pin level through the chain; the last flop is the clean copy
      always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= {N{RST_VAL}};
        else     ff <= {ff[N-2:0], d};
      end
    end
  endgenerate

  assign q = ff[N-1];

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - oversampling SPI receiver, LSB-first, valid/ready word output
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_rx_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [FW-1:0] FILLED   = FW'(SYNC_STAGES);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;
  logic [FW-1:0] fill;
  logic armed;

  rx_state_t        state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dout_r;
  logic             dout_valid_r;
  logic             busy_r;
  logic             frame_err_r;
  logic             overrun_r;

  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(bus.sclk), .q(sclk_s)
  );
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(bus.cs), .q(cs_s)
  );
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(bus.mosi), .q(mosi_s)
  );

  // one-cycle-delayed copies for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  wire sclk_fall = sclk_d & ~sclk_s;
  wire cs_rise   = ~cs_d & cs_s;
  wire cs_fall   = cs_d & ~cs_s;

  // Until the synchronizer holds real pin samples, cs_s is only its reset value.
  // Frames are accepted only after a genuine high cs has been seen, so a cs held
  // low across reset never looks like a new frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      if (fill != FILLED) fill <= fill + 1'b1;
      if (fill == FILLED && cs_s) armed <= 1'b1;
    end
  end

  wire [WIDTH-1:0] sr_next = {mosi_s, sr[WIDTH-1:1]};

  // frame FSM, deserializer and output handshake; cs rise outranks sclk fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sr           <= '0;
      cnt          <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      if (dout_valid_r && bus.dout_ready) dout_valid_r <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            cnt    <= '0;
            state  <= LEAD;
            busy_r <= 1'b1;
          end
        end
        LEAD: begin
          if (cs_rise) begin
            frame_err_r <= 1'b1;
            sr          <= '0;
            state       <= IDLE;
            busy_r      <= 1'b0;
          end else if (sclk_fall) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            frame_err_r <= 1'b1;
            sr          <= '0;
            state       <= IDLE;
            busy_r      <= 1'b0;
          end else if (sclk_fall) begin
            sr  <= sr_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BIT) begin
              state <= DONE;
              if (!dout_valid_r || bus.dout_ready) begin
                dout_r       <= sr_next;
                dout_valid_r <= 1'b1;
              end else begin
                overrun_r <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (cs_rise) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.busy       = busy_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - randomized self-checking bench for spi_slave_rx
module tb_spi_slave_rx;
  import spi_pkg::*;

  localparam int W = SPI_WORD_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_slave_rx_if bif ();

  spi_slave_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  int n_ferr = 0, n_ovr = 0, n_vrise = 0, n_stab_bad = 0, n_pulse_bad = 0;
  logic pv = 1'b0, pr = 1'b0, pf = 1'b0, po = 1'b0;
  logic [W-1:0] pd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // consumer-side scoreboard: every accepted word must be the next expected one
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0; pr = 1'b0; pf = 1'b0; po = 1'b0;
    end else begin
      if (bif.dout_valid && !pv) n_vrise++;
      if (bif.frame_err) n_ferr++;
      if (bif.overrun) n_ovr++;
      if ((bif.frame_err && pf) || (bif.overrun && po)) n_pulse_bad++;
      if (pv && !pr && bif.dout !== pd) n_stab_bad++;
      if (bif.dout_valid && bif.dout_ready) begin
        if (exp_q.size() == 0) check("extra_word", 32'(exp_q.size()), 1);
        else check("dout_word", 32'(bif.dout), 32'(exp_q.pop_front()));
      end
      pv = bif.dout_valid; pr = bif.dout_ready; pd = bif.dout;
      pf = bif.frame_err;  po = bif.overrun;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master model: cs low, one lead-in sclk cycle, then nbits data cycles with mosi
  // updated on the rising edge, LSB first. Optional reset pulse at data bit rst_bit;
  // optional ready pulse timed to land on the edge that completes the word.
  task automatic send_frame(input logic [W-1:0] w, input int nbits, input int h,
                            input int rst_bit, input bit coincide);
    bif.cs = 1'b0;
    tick(h);
    for (int k = 0; k <= nbits; k++) begin
      bif.sclk = 1'b1;
      if (k > 0) bif.mosi = w[k-1];
      if (k == rst_bit) begin
        rst = 1'b1;
        tick(2);
        check("rst_dout", 32'(bif.dout), 0);
        check("rst_valid", 32'(bif.dout_valid), 0);
        check("rst_busy", 32'(bif.busy), 0);
        check("rst_ferr", 32'(bif.frame_err), 0);
        check("rst_ovr", 32'(bif.overrun), 0);
        rst = 1'b0;
      end
      tick(h);
      if (k == 3 && (rst_bit < 0 || rst_bit > 3)) check("busy_mid", 32'(bif.busy), 1);
      if (rst_bit >= 0 && k == nbits) check("busy_after_rst", 32'(bif.busy), 0);
      bif.sclk = 1'b0;
      if (coincide && k == nbits) begin
        tick(2);
        bif.dout_ready = 1'b1;
        tick(1);
        bif.dout_ready = 1'b0;
        tick(h - 3);
      end else begin
        tick(h);
      end
    end
    bif.cs = 1'b1;
    tick(h);
    check("busy_end", 32'(bif.busy), 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick(1);
    check("drain", 32'(exp_q.size()), 0);
  endtask

  int v0, h;
  logic [W-1:0] w1, w2;
  bit rnd_done;

  initial begin
    bif.sclk = 1'b0; bif.cs = 1'b1; bif.mosi = 1'b0; bif.dout_ready = 1'b0;
    rst = 1'b1;
    tick(3);
    check("reset_dout", 32'(bif.dout), 0);
    check("reset_valid", 32'(bif.dout_valid), 0);
    check("reset_busy", 32'(bif.busy), 0);
    check("reset_ferr", 32'(bif.frame_err), 0);
    check("reset_ovr", 32'(bif.overrun), 0);
    rst = 1'b0;
    tick(6);

    // single frame
    bif.dout_ready = 1'b1;
    exp_q.push_back(12'hA5C);
    send_frame(12'hA5C, W, 6, -1, 1'b0);
    wait_drain();
    check("t1_vrise", n_vrise, 1);
    check("t1_ferr", n_ferr, 0);
    check("t1_ovr", n_ovr, 0);

    // back-to-back frames
    exp_q.push_back(12'h001);
    exp_q.push_back(12'h800);
    send_frame(12'h001, W, 5, -1, 1'b0);
    send_frame(12'h800, W, 5, -1, 1'b0);
    wait_drain();
    check("t2_vrise", n_vrise, 3);

    // overrun: second word dropped while first still pending
    bif.dout_ready = 1'b0;
    exp_q.push_back(12'h123);
    send_frame(12'h123, W, 4, -1, 1'b0);
    tick(5);
    check("t3_valid", 32'(bif.dout_valid), 1);
    check("t3_dout", 32'(bif.dout), 12'h123);
    send_frame(12'hFFF, W, 4, -1, 1'b0);
    tick(5);
    check("t3_ovr", n_ovr, 1);
    check("t3_dout_kept", 32'(bif.dout), 12'h123);
    bif.dout_ready = 1'b1;
    wait_drain();

    // short frame: 5 bits then cs rises
    v0 = n_vrise;
    send_frame(12'h2AA, 5, 6, -1, 1'b0);
    tick(10);
    check("t4_ferr", n_ferr, 1);
    check("t4_no_valid", n_vrise, v0);
    exp_q.push_back(12'h3C3);
    send_frame(12'h3C3, W, 6, -1, 1'b0);
    wait_drain();
    check("t4_vrise", n_vrise, v0 + 1);

    // reset during bit 6 with cs low: frame ignored, next frame received
    v0 = n_vrise;
    send_frame(12'h9E7, W, 6, 6, 1'b0);
    tick(8);
    check("t5_ignored", n_vrise, v0);
    exp_q.push_back(12'h555);
    send_frame(12'h555, W, 6, -1, 1'b0);
    wait_drain();
    check("t5_ferr", n_ferr, 1);
    check("t5_vrise", n_vrise, v0 + 1);

    // completion coincides with acceptance of previous word
    bif.dout_ready = 1'b0;
    w1 = W'($urandom);
    w2 = W'($urandom);
    exp_q.push_back(w1);
    send_frame(w1, W, 5, -1, 1'b0);
    v0 = n_vrise;
    exp_q.push_back(w2);
    send_frame(w2, W, 5, -1, 1'b1);
    check("t6_ovr", n_ovr, 1);
    check("t6_valid", 32'(bif.dout_valid), 1);
    check("t6_no_gap", n_vrise, v0);
    check("t6_dout", 32'(bif.dout), 32'(w2));
    check("t6_q_left", 32'(exp_q.size()), 1);
    bif.dout_ready = 1'b1;
    wait_drain();

    // random words, random sclk timing, random consumer stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          w1 = W'($urandom);
          h  = $urandom_range(4, 8);
          exp_q.push_back(w1);
          send_frame(w1, W, h, -1, 1'b0);
          tick($urandom_range(0, 6));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          bif.dout_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    bif.dout_ready = 1'b1;
    wait_drain();
    check("rnd_ferr", n_ferr, 1);
    check("rnd_ovr", n_ovr, 1);
    check("pulse_width", n_pulse_bad, 0);
    check("dout_stable", n_stab_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI receive stage that sits directly downstream of the team's 12-bit LSB-first SPI master. It oversamples the master's `sclk`/`cs`/`mosi` in the system `clk` domain and deserializes each frame into a parallel word. Each word is presented on a valid/ready output port. Short frames and dropped words are flagged for the consuming logic.

## Interface
- `WIDTH`, 12: data bits per frame; matches the master's word size.
- `SYNC_STAGES`, 2: synchronizer depth for `sclk`, `cs`, `mosi`.

- `clk` input 1: system clock, the same clock that drives the master; the only clock in the block.
- `rst` input 1: asynchronous, active-high reset.
- `sclk` input 1: serial clock from the master; asynchronous to `clk` by assumption.
- `cs` input 1: active-low chip select.
- `mosi` input 1: serial data, LSB first; changes on rising `sclk`.
- `dout` output WIDTH: last completed word.
- `dout_valid` output 1: `dout` holds an unconsumed word.
- `dout_ready` input 1: consumer accepts `dout` this cycle.
- `busy` output 1: a frame is in progress (state is not IDLE).
- `frame_err` output 1: one-cycle pulse; `cs` rose before `WIDTH` bits arrived.
- `overrun` output 1: one-cycle pulse; a completed word was dropped because `dout_valid` was still high.

## Operation
- `sclk`, `cs` and `mosi` pass through `SYNC_STAGES` flops, giving `sclk_s`, `cs_s`, `mosi_s`. Edge detection uses one extra registered copy.
- Reset values of the synchronizers: `cs` 1, `sclk` 0, `mosi` 0.
- Bits are sampled on the falling edge of `sclk_s`, which is mid-bit for the master.
- The master leaves one falling edge before bit 0 while `cs` is already low. This lead-in edge is discarded.
- State machine:
  - IDLE: on a falling edge of `cs_s`, clear the bit counter and go to LEAD. A `cs_s` that is already low on exit from reset is ignored until it goes high and then low again.
  - LEAD: on the first `sclk_s` fall, go to SHIFT. No bit is captured.
  - SHIFT: on each `sclk_s` fall, shift right, `sr <= {mosi_s, sr[WIDTH-1:1]}`, and increment the count. On the `WIDTH`-th bit, deliver the word and go to DONE.
  - DONE: ignore further `sclk_s` falls. On a `cs_s` rise, go to IDLE.
  - A `cs_s` rise in LEAD or SHIFT pulses `frame_err`, discards the partial word and returns to IDLE.
- Delivering a word:
  - `dout_valid` low: load `dout` with the word and set `dout_valid`.
  - `dout_valid` high and `dout_ready` high in the same cycle: the old word is consumed, the new word loads, and `dout_valid` stays 1.
  - `dout_valid` high and `dout_ready` low: pulse `overrun`, keep the old `dout`, drop the new word.
- Handshake: a transfer happens on any clk edge with `dout_valid && dout_ready`. `dout_valid` then clears unless a new word loads on the same edge. `dout` is stable while `dout_valid && !dout_ready`.
- Priority when a `cs_s` rise and an `sclk_s` fall land in the same cycle: the `cs` rise wins.
- Bit counter width is `$clog2(WIDTH+1)`. It never wraps within a frame.

## Timing
- Reset values: `dout` 0, `dout_valid` 0, `busy` 0, `frame_err` 0, `overrun` 0. State resets to IDLE and the shift register to 0.
- Reset mid-frame drops the partial word and produces no `frame_err` pulse.
- Input-to-event latency: `SYNC_STAGES`+1 clk edges from the first clk edge that samples the new pin level. That is 3 cycles at default.
- `dout_valid` rises on the clk edge that captures the 12th bit.
- `busy` rises on the edge entering LEAD and falls on the edge entering IDLE.
- `frame_err` and `overrun` are high for exactly one clk cycle per event.
- Minimum `sclk` high or low time is `SYNC_STAGES`+2 clk cycles. The master's 51-cycle half-period satisfies this easily.

## Structure
- Shared package `spi_pkg` holds:
  - `rx_state_t` enum: IDLE, LEAD, SHIFT, DONE.
  - `SPI_WORD_W` = 12, also used by the master.
  - `SPI_LEAD_EDGES` = 1.
- One sub-module, `spi_sync`: a parameterised N-flop synchronizer with a reset-value parameter. The block instantiates it three times.

## Test plan
- Master sends 12'hA5C -> `dout` = 12'hA5C with one `dout_valid` rise; `frame_err` and `overrun` stay 0.
- Back-to-back frames 12'h001 then 12'h800 with `dout_ready` tied to 1 -> two transfers, values in order.
- Frame 12'h123 with `dout_ready` = 0, then frame 12'hFFF -> `overrun` pulses once; `dout` stays 12'h123 until accepted.
- Force `cs` high after 5 captured bits -> `frame_err` pulses once, no `dout_valid`; the next full frame 12'h3C3 is received correctly.
- Assert `rst` during bit 6 of a frame with `cs` still low -> outputs return to reset values, that frame is ignored, and the following frame 12'h555 is received.
- Word completes on the same edge that `dout_ready` accepts the previous word -> no `overrun`; `dout_valid` stays 1; `dout` updates to the new word.
